// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: start control, instruction-memory read port, core
// issue port and status, bundled for the fetch unit and its environment.
interface instr_fetch_unit_if #(
  parameter int INSTRUCTION_WIDTH = 15,
  parameter int ADDRESS_WIDTH     = 16,
  parameter int WORD_WIDTH        = 16
);
  // control
  logic                         start;
  logic [ADDRESS_WIDTH-1:0]     start_address;
  // instruction memory
  logic [ADDRESS_WIDTH-1:0]     imem_address;
  logic                         imem_rden;
  logic [WORD_WIDTH-1:0]        imem_q;
  // core side
  logic                         core_busy;
  logic [INSTRUCTION_WIDTH-1:0] instruction;
  logic                         instr_valid;
  // status
  logic [ADDRESS_WIDTH-1:0]     pc;
  logic                         running;
  logic                         halted;

  // fetch unit side
  modport master (
    input  start, start_address, imem_q, core_busy,
    output imem_address, imem_rden, instruction, instr_valid, pc, running, halted
  );

  // memory / core / controller side
  modport slave (
    output start, start_address, imem_q, core_busy,
    input  imem_address, imem_rden, instruction, instr_valid, pc, running, halted
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches 16-bit words from a 1-cycle-latency instruction
// memory into a small prefetch FIFO and issues one 15-bit instruction per
// cycle to the core. A word with bit 15 set is a HALT marker: fetching stops,
// the FIFO drains, then the unit parks in HALTED. Idle cycles issue NOP_WORD.
module instr_fetch_unit #(
  parameter int                           INSTRUCTION_WIDTH = 15,
  parameter int                           ADDRESS_WIDTH     = 16,
  parameter int                           WORD_WIDTH        = 16,
  parameter int                           FIFO_DEPTH        = 4,
  parameter logic [INSTRUCTION_WIDTH-1:0] NOP_WORD          = 15'h02C0
) (
  input logic                clk,
  input logic                reset,
  instr_fetch_unit_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALTED} state_t;

  state_t                       state;
  logic [ADDRESS_WIDTH-1:0]     pc_q;
  logic [INSTRUCTION_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr;
  logic [PTR_W-1:0]             rd_ptr;
  logic [CNT_W-1:0]             count;
  logic                         inflight;  // a read was issued last cycle

  logic                         active;
  logic                         request;
  logic                         word_back;
  logic                         halt_seen;
  logic                         push;
  logic                         bypass;
  logic                         pop;
  logic                         store;
  logic [CNT_W-1:0]             occupancy;
  logic [INSTRUCTION_WIDTH-1:0] head;

  // Request, return and issue decisions for the current cycle.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    active      = 1'b0;
    request     = 1'b0;
    word_back   = 1'b0;
    halt_seen   = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    store       = 1'b0;
    occupancy   = count + CNT_W'(inflight);
    bypass      = (count == '0);
    head        = bypass ? bus.imem_q[INSTRUCTION_WIDTH-1:0] : fifo_mem[rd_ptr];

    active      = (state == FETCH) || (state == DRAIN);
    // Keep one slot reserved for the word still on its way back.
    request     = (state == FETCH) && (occupancy < DEPTH_CNT);
    // Returns that arrive after HALT (state already DRAIN) are discarded.
    word_back   = (state == FETCH) && inflight;
    halt_seen   = word_back && bus.imem_q[WORD_WIDTH-1];
    push        = word_back && !bus.imem_q[WORD_WIDTH-1];
    pop         = active && (push || !bypass) && !bus.core_busy;
    // An empty FIFO hands the returning word straight to the core.
    store       = push && !(pop && bypass);

    bus.instruction = pop ? head : NOP_WORD;
    bus.instr_valid = pop;
  end

  assign bus.imem_rden    = request;
  assign bus.imem_address = pc_q;
  assign bus.pc           = pc_q;
  assign bus.running      = active;
  assign bus.halted       = (state == HALTED);

  // Sequencer: state, fetch pointer, in-flight flag and FIFO bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state    <= IDLE;
      pc_q     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      if (store) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop && !bypass) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop) count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);

      case (state)
        IDLE, HALTED: begin
          if (bus.start) begin
            state    <= FETCH;
            pc_q     <= bus.start_address;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
          end
        end
        FETCH: begin
          inflight <= request;
          if (request) pc_q <= pc_q + ADDRESS_WIDTH'(1);
          if (halt_seen) state <= DRAIN;
        end
        DRAIN: begin
          inflight <= 1'b0;
          if (count == '0) state <= HALTED;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; count and pointers define validity.
    if (store) fifo_mem[wr_ptr] <= bus.imem_q[INSTRUCTION_WIDTH-1:0];
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: cycle-exact vector table for the basic program, hand
// sequences for busy-stall, wrap and mid-run reset, plus randomized programs
// and core_busy patterns checked against a program-level reference model.
module tb_instr_fetch_unit;
  localparam logic [14:0] NOP = 15'h02C0;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus ();
  instr_fetch_unit dut (.clk(clk), .reset(reset), .bus(bus.master));

  logic [15:0] mem [65536];
  logic [14:0] issued_q [$];
  logic [15:0] req_q [$];
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        busy;
    logic        valid;
    logic [14:0] instr;
    logic        rden;
    logic [15:0] addr;
    logic [15:0] pc;
    logic        running;
    logic        halted;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Synchronous instruction memory, one cycle read latency.
  always @(posedge clk) begin
    if (bus.imem_rden) bus.imem_q <= mem[bus.imem_address];
  end

  // Mid-cycle monitor: record issues and reads, police idle and busy cycles.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.instr_valid) issued_q.push_back(bus.instruction);
      else check("nop_when_idle", 32'(bus.instruction), 32'(NOP));
      if (bus.core_busy) check("valid_while_busy", 32'(bus.instr_valid), 0);
      if (bus.imem_rden) req_q.push_back(bus.imem_address);
    end
  end

  task automatic pulse_start(input logic [15:0] a);
    @(posedge clk); #2;
    bus.start = 1'b1;
    bus.start_address = a;
    @(posedge clk); #2;
    bus.start = 1'b0;
  endtask

  task automatic load_program(input logic [15:0] a, input int n);
    for (int i = 0; i < n; i++) mem[16'(a + i)] = {1'b0, 15'($urandom)};
    mem[16'(a + n)]     = 16'h8000 | 16'($urandom_range(0, 32767));
    mem[16'(a + n + 1)] = {1'b0, 15'($urandom)};
  endtask

  // mode: 0 never busy, 1 toggle, 2 random, 3 busy for first 10 cycles
  task automatic run_program(input string tag, input logic [15:0] base,
                             input int mode, input bit poke);
    logic [14:0] exp_q [$];
    logic [15:0] a;
    int cyc;
    bit done;
    // Reference: words from base (wrapping) up to the first HALT marker.
    a = base;
    while (!mem[a][15] && exp_q.size() < 64) begin
      exp_q.push_back(mem[a][14:0]);
      a = a + 16'd1;
    end
    issued_q.delete();
    req_q.delete();
    pulse_start(base);
    check({tag, "_halted_low"}, 32'(bus.halted), 0);
    check({tag, "_running"}, 32'(bus.running), 1);
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 400) begin
      if (mode == 3 && cyc == 10) begin
        check({tag, "_busy_reads"}, req_q.size(), 4);
        check({tag, "_busy_issued"}, issued_q.size(), 0);
      end
      case (mode)
        1:       bus.core_busy = ((cyc % 2) == 1);
        2:       bus.core_busy = ($urandom_range(0, 2) == 0);
        3:       bus.core_busy = (cyc < 10);
        default: bus.core_busy = 1'b0;
      endcase
      bus.start         = poke && (cyc == 3);
      bus.start_address = (poke && cyc == 3) ? 16'h5555 : base;
      @(posedge clk); #2;
      cyc++;
      done = bus.halted;
    end
    bus.core_busy = 1'b0;
    bus.start     = 1'b0;
    check({tag, "_halt_reached"}, 32'(done), 1);
    check({tag, "_issue_count"}, issued_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < issued_q.size(); i++)
      check({tag, "_issue_word"}, 32'(issued_q[i]), 32'(exp_q[i]));
    // Reads cover the program plus HALT, with at most one discarded extra.
    check({tag, "_reads_min"}, 32'(req_q.size() >= exp_q.size() + 1), 1);
    check({tag, "_reads_max"}, 32'(req_q.size() <= exp_q.size() + 2), 1);
    for (int i = 0; i < req_q.size(); i++)
      check({tag, "_read_addr"}, 32'(req_q[i]), 32'(16'(base + i)));
    check({tag, "_pc_final"}, 32'(bus.pc), 32'(16'(base + req_q.size())));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start         = 1'b0;
    bus.start_address = '0;
    bus.core_busy     = 1'b0;

    // Reset values
    #1 reset = 1'b1;
    #2;
    check("rst_rden", 32'(bus.imem_rden), 0);
    check("rst_addr", 32'(bus.imem_address), 0);
    check("rst_pc", 32'(bus.pc), 0);
    check("rst_valid", 32'(bus.instr_valid), 0);
    check("rst_instr", 32'(bus.instruction), 32'(NOP));
    check("rst_running", 32'(bus.running), 0);
    check("rst_halted", 32'(bus.halted), 0);
    @(posedge clk); #2 reset = 1'b0;

    // Cycle-exact table for program 0x10..0x13 with core_busy low
    mem[16'h0010] = 16'h1111;
    mem[16'h0011] = 16'h2222;
    mem[16'h0012] = 16'h3333;
    mem[16'h0013] = 16'h8000;
    mem[16'h0014] = 16'h7777;
    //            busy  valid instr      rden  addr      pc        run   halt
    vecs[0] = '{1'b0, 1'b0, NOP,       1'b1, 16'h0010, 16'h0010, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 15'h1111,  1'b1, 16'h0011, 16'h0011, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 15'h2222,  1'b1, 16'h0012, 16'h0012, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 15'h3333,  1'b1, 16'h0013, 16'h0013, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, NOP,       1'b1, 16'h0014, 16'h0014, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, NOP,       1'b0, 16'h0000, 16'h0015, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, NOP,       1'b0, 16'h0000, 16'h0015, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, NOP,       1'b0, 16'h0000, 16'h0015, 1'b0, 1'b1};
    pulse_start(16'h0010);
    foreach (vecs[i]) begin
      bus.core_busy = vecs[i].busy;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 32'(bus.instr_valid), 32'(vecs[i].valid));
      check($sformatf("vec%0d_instr", i), 32'(bus.instruction), 32'(vecs[i].instr));
      check($sformatf("vec%0d_rden", i), 32'(bus.imem_rden), 32'(vecs[i].rden));
      if (vecs[i].rden)
        check($sformatf("vec%0d_addr", i), 32'(bus.imem_address), 32'(vecs[i].addr));
      check($sformatf("vec%0d_pc", i), 32'(bus.pc), 32'(vecs[i].pc));
      check($sformatf("vec%0d_running", i), 32'(bus.running), 32'(vecs[i].running));
      check($sformatf("vec%0d_halted", i), 32'(bus.halted), 32'(vecs[i].halted));
      @(posedge clk); #2;
    end

    // Same program, core busy for the first 10 cycles; restart from HALTED
    run_program("busy10", 16'h0010, 3, 1'b0);

    // Address wrap 0xFFFE -> 0x0000
    mem[16'hFFFE] = 16'h0001;
    mem[16'hFFFF] = 16'h0002;
    mem[16'h0000] = 16'h8000;
    mem[16'h0001] = 16'h0ABC;
    run_program("wrap", 16'hFFFE, 0, 1'b0);

    // 20 words with core_busy toggling, plus an ignored start pulse mid-run
    load_program(16'h0100, 20);
    run_program("toggle", 16'h0100, 1, 1'b1);

    // Reset for one cycle in the middle of a program
    load_program(16'h0200, 12);
    pulse_start(16'h0200);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_valid", 32'(bus.instr_valid), 0);
    check("midrst_instr", 32'(bus.instruction), 32'(NOP));
    check("midrst_rden", 32'(bus.imem_rden), 0);
    check("midrst_addr", 32'(bus.imem_address), 0);
    check("midrst_pc", 32'(bus.pc), 0);
    check("midrst_running", 32'(bus.running), 0);
    check("midrst_halted", 32'(bus.halted), 0);
    @(posedge clk); #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("idle_after_rst", 32'(bus.running), 0);
    load_program(16'h0020, 5);
    run_program("restart20", 16'h0020, 0, 1'b0);

    // Randomized programs, start addresses and stall patterns
    for (int r = 0; r < 25; r++) begin
      logic [15:0] base;
      int n;
      base = (r % 5 == 0) ? 16'($urandom_range(32'hFFEC, 32'hFFFF))
                          : 16'($urandom_range(32'h0400, 32'hF000));
      n = $urandom_range(0, 20);
      load_program(base, n);
      run_program($sformatf("rand%0d", r), base, 2, n >= 10);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Upstream instruction feeder for the core. It fetches 16-bit words from a synchronous instruction memory starting at a programmed address and buffers them in a small prefetch FIFO. It presents one 15-bit instruction per cycle to the core's instruction input, stalling while the core reports busy and stopping cleanly on a HALT word. When it has nothing valid to issue, it drives a never-executing NOP (condition field NV) so the core stays idle.

Parameters:
INSTRUCTION_WIDTH, 15, width of the instruction presented to the core
ADDRESS_WIDTH, 16, instruction memory address / PC width
WORD_WIDTH, 16, instruction memory word width; bit 15 = HALT marker
FIFO_DEPTH, 4, prefetch FIFO entries (power of two, >=2)
NOP_WORD, 15'h02C0, idle instruction (bits[9:6]=4'b1011, condition NV)

Ports:
clk  input  1  single clock, all state on posedge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  one-cycle pulse; begin fetching at start_address
start_address  input  ADDRESS_WIDTH  first fetch address, sampled on start
imem_address  output  ADDRESS_WIDTH  instruction memory read address
imem_rden  output  1  read strobe; data returns on imem_q exactly 1 cycle later
imem_q  input  WORD_WIDTH  instruction memory read data
core_busy  input  1  core cannot accept an instruction this cycle
instruction  output  INSTRUCTION_WIDTH  instruction to core (NOP_WORD when not valid)
instr_valid  output  1  instruction is real and consumed this cycle
pc  output  ADDRESS_WIDTH  address of the next word to be requested
running  output  1  high in FETCH or DRAIN
halted  output  1  high in HALTED

Behaviour:
- Reset (async): state=IDLE, pc=0, FIFO empty, in-flight=0, imem_rden=0, imem_address=0, instruction=NOP_WORD, instr_valid=0, running=0, halted=0.
- States: IDLE, FETCH, DRAIN, HALTED.
- IDLE/HALTED + start: pc<=start_address, FIFO flushed, in-flight cleared, go to FETCH, halted<=0. A start pulse in FETCH/DRAIN is ignored.
- FETCH, request rule: assert imem_rden with imem_address=pc when (fifo_count + inflight) < FIFO_DEPTH; then pc<=pc+1, wrapping 16'hFFFF->0. inflight is 0 or 1 because latency is 1.
- Return: the cycle after a request, imem_q is pushed unless it is being discarded. Word with bit15=1 is HALT: not pushed, all further requests stop, any in-flight word returning afterwards is discarded, state->DRAIN.
- Issue (FETCH or DRAIN): if FIFO non-empty and core_busy=0 then instruction=head[14:0], instr_valid=1, pop. Otherwise instruction=NOP_WORD, instr_valid=0. Issue is combinational from the FIFO head. Push and pop in the same cycle are allowed, so the count is unchanged.
- Full FIFO: never overflows, because the request rule reserves a slot for the in-flight word.
- Throughput: 1 instruction/cycle sustained with core_busy=0. The first instr_valid comes 2 cycles after start: request at cycle+1, data pushed at +2 and issued the same cycle via bypass when the FIFO is empty.
- DRAIN: no requests. When the FIFO is empty, go to HALTED (halted=1, running=0) on the next edge.
- core_busy held: FIFO fills to FIFO_DEPTH, then requests stop. pc holds at the last requested address + 1.
- Reset mid-operation: immediate return to reset values. Discarded in-flight data is ignored.
- pc reports the next request address, not the issued instruction's address.

Test Plan:
- Memory 0x10..0x13 = 0x1111,0x2222,0x3333,0x8000; start, start_address=0x10, core_busy=0 -> instr_valid on 3 consecutive cycles with 15'h1111,15'h2222,15'h3333; then halted=1; imem_rden never asserted for 0x14 beyond one discarded read.
- Same program, core_busy=1 for 10 cycles after start -> 4 reads max (3 instructions + HALT seen), instr_valid=0, instruction=15'h02C0; release -> three instructions in order, no loss/duplication.
- start_address=0xFFFE with words 0x0001,0x0002 at 0xFFFE/0xFFFF and 0x8000 at 0x0000 -> pc wraps to 0, issues 0x0001,0x0002, halts.
- core_busy toggled every cycle on a 20-word program -> exactly 20 instr_valid pulses, data equal to memory order.
- Assert reset for 1 cycle mid-program -> outputs return to reset values immediately, state IDLE; second start at 0x20 fetches from 0x20 only.
- start pulse while running -> ignored (pc sequence unchanged); start after HALTED -> restarts cleanly, halted drops.
